ysyx_24080006_rd_arbiter: RTL and testbench

Two-requester AXI read-channel arbiter that shares the core's single AXI read master between the IFU and the LSU. It sits between the fetch/load-store units and the interconnect, one transaction in flight at a time. Ownership is held from AR handshake through the final R beat, so bursts are never interleaved. A beat counter checks `rlast` against `arlen`.

---
 rtl/OoO_pkg.sv | 33 +++
 rtl/ysyx_24080006_rd_arb_pick.sv | 27 ++
 rtl/ysyx_24080006_rd_arbiter.sv | 124 ++++++++++++
 tb/tb_ysyx_24080006_rd_arbiter.sv | 465 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/OoO_pkg.sv
// rtl/OoO_pkg.sv - shared AXI read-channel types and read-arbiter enums
package OoO_pkg;

   typedef struct packed {
      logic        arvalid;
      logic [31:0] araddr;
      logic [3:0]  arid;
      logic [7:0]  arlen;
      logic [2:0]  arsize;
      logic [1:0]  arburst;
      logic        rready;
   } axi_r_m2s_t;

   typedef struct packed {
      logic        arready;
      logic        rvalid;
      logic [31:0] rdata;
      logic [1:0]  rresp;
      logic        rlast;
   } axi_r_s2m_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      DATA = 2'd2
   } rd_arb_state_e;

   typedef enum logic {
      OWNER_IFU = 1'b0,
      OWNER_LSU = 1'b1
   } rd_arb_owner_e;

endpackage

// File: rtl/ysyx_24080006_rd_arb_pick.sv
// rtl/ysyx_24080006_rd_arb_pick.sv - combinational winner selection for the read arbiter
// YSYX_RD_ARB_RR_EN: round-robin tie-break on last grant; otherwise the LSU wins ties.
module ysyx_24080006_rd_arb_pick
   import OoO_pkg::*;
(
   input  logic          ifu_req,
   input  logic          lsu_req,
`ifdef YSYX_RD_ARB_RR_EN
   input  rd_arb_owner_e last_grant,
`endif
   output rd_arb_owner_e winner
);

   always_comb begin
      winner = OWNER_IFU;
      if (ifu_req && lsu_req) begin
`ifdef YSYX_RD_ARB_RR_EN
         winner = (last_grant == OWNER_LSU) ? OWNER_IFU : OWNER_LSU;
`else
         winner = OWNER_LSU;
`endif
      end else if (lsu_req) begin
         winner = OWNER_LSU;
      end
   end

endmodule

// File: rtl/ysyx_24080006_rd_arbiter.sv
// rtl/ysyx_24080006_rd_arbiter.sv - two-requester AXI read arbiter, whole-burst ownership
// YSYX_RD_ARB_RR_EN selects round-robin arbitration; default is fixed LSU priority.
module ysyx_24080006_rd_arbiter
   import OoO_pkg::*;
#(
   parameter int BEAT_W = 8
) (
   input  logic       clock,
   input  logic       reset,
   input  axi_r_m2s_t ifu_r_m2s,
   output axi_r_s2m_t ifu_r_s2m,
   input  axi_r_m2s_t lsu_r_m2s,
   output axi_r_s2m_t lsu_r_s2m,
   output axi_r_m2s_t core_r_m2s,
   input  axi_r_s2m_t core_r_s2m,
   output logic       busy_o,
   output logic       owner_o,
   output logic       proto_err_o
);

   rd_arb_state_e     state, state_nxt;
   rd_arb_owner_e     owner, winner;
   logic [BEAT_W-1:0] beat_cnt, len_q;
   logic              proto_err;
   axi_r_m2s_t        own_req;
   axi_r_s2m_t        own_rsp;
   logic              grant, ar_hs, r_beat, r_done, err_set;

`ifdef YSYX_RD_ARB_RR_EN
   rd_arb_owner_e     last_grant;
`endif

   ysyx_24080006_rd_arb_pick u_pick (
      .ifu_req    (ifu_r_m2s.arvalid),
      .lsu_req    (lsu_r_m2s.arvalid),
`ifdef YSYX_RD_ARB_RR_EN
      .last_grant (last_grant),
`endif
      .winner     (winner)
   );

   assign own_req = (owner == OWNER_LSU) ? lsu_r_m2s : ifu_r_m2s;

   always_comb begin
      state_nxt  = state;
      grant      = 1'b0;
      ar_hs      = 1'b0;
      r_beat     = 1'b0;
      r_done     = 1'b0;
      core_r_m2s = '0;
      own_rsp    = '0;
      ifu_r_s2m  = '0;
      lsu_r_s2m  = '0;
      case (state)
         IDLE: begin
            if (ifu_r_m2s.arvalid || lsu_r_m2s.arvalid) begin
               grant     = 1'b1;
               state_nxt = ADDR;
            end
         end
         ADDR: begin
            core_r_m2s        = own_req;
            core_r_m2s.rready = 1'b0;
            own_rsp.arready   = core_r_s2m.arready;
            if (own_req.arvalid && core_r_s2m.arready) begin
               ar_hs     = 1'b1;
               state_nxt = DATA;
            end
         end
         DATA: begin
            core_r_m2s.rready = own_req.rready;
            own_rsp           = core_r_s2m;
            own_rsp.arready   = 1'b0;
            r_beat            = core_r_s2m.rvalid && own_req.rready;
            if (r_beat && core_r_s2m.rlast) begin
               r_done    = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
      // Only the owner ever sees the slave; the other side stays zeroed and keeps waiting.
      if (owner == OWNER_LSU) lsu_r_s2m = own_rsp;
      else                    ifu_r_s2m = own_rsp;
   end

   // A saturated counter can only be passed by a burst that already overran len_q.
   assign err_set = r_beat && (core_r_s2m.rlast ? (beat_cnt != len_q)
                                                : ((beat_cnt == len_q) || (&beat_cnt)));

   always_ff @(posedge clock) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         owner     <= OWNER_IFU;
         beat_cnt  <= '0;
         len_q     <= '0;
         proto_err <= 1'b0;
      end else begin
         if (grant) begin
            owner    <= winner;
            beat_cnt <= '0;
         end
         if (ar_hs) len_q <= BEAT_W'(own_req.arlen);
         if (r_beat && !(&beat_cnt)) beat_cnt <= beat_cnt + BEAT_W'(1);
         if (err_set) proto_err <= 1'b1;
      end
   end

`ifdef YSYX_RD_ARB_RR_EN
   always_ff @(posedge clock) begin
      if (reset)       last_grant <= OWNER_LSU;
      else if (r_done) last_grant <= owner;
   end
`endif

   assign busy_o      = (state != IDLE);
   assign owner_o     = owner;
   assign proto_err_o = proto_err;

endmodule

// File: tb/tb_ysyx_24080006_rd_arbiter.sv
// tb/tb_ysyx_24080006_rd_arbiter.sv - randomized self-checking bench for the read arbiter
module tb_ysyx_24080006_rd_arbiter;
   import OoO_pkg::*;

   logic       clock, reset;
   axi_r_m2s_t ifu_m2s, lsu_m2s, core_m2s;
   axi_r_s2m_t ifu_s2m, lsu_s2m, core_s2m;
   logic       busy_o, owner_o, proto_err_o;

   int vectors, miscompares;
   bit m_last_lsu;

   ysyx_24080006_rd_arbiter #(.BEAT_W(8)) dut (
      .clock       (clock),
      .reset       (reset),
      .ifu_r_m2s   (ifu_m2s),
      .ifu_r_s2m   (ifu_s2m),
      .lsu_r_m2s   (lsu_m2s),
      .lsu_r_s2m   (lsu_s2m),
      .core_r_m2s  (core_m2s),
      .core_r_s2m  (core_s2m),
      .busy_o      (busy_o),
      .owner_o     (owner_o),
      .proto_err_o (proto_err_o)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // Reference arbitration: single requester always wins; ties follow the configured policy.
   function automatic bit exp_winner(input bit i, input bit l);
      if (i && !l) return 1'b0;
      if (l && !i) return 1'b1;
`ifdef YSYX_RD_ARB_RR_EN
      return !m_last_lsu;
`else
      return 1'b1;
`endif
   endfunction

   task automatic do_reset();
      reset = 1'b1;
      ifu_m2s = '0;
      lsu_m2s = '0;
      core_s2m = '0;
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b0;
      m_last_lsu = 1'b1;
   endtask

   task automatic arm(input bit lsu);
      axi_r_m2s_t r;
      r = '0;
      r.arvalid = 1'b1;
      r.araddr  = $urandom & 32'hFFFF_FFFC;
      r.arid    = 4'($urandom_range(0, 15));
      r.arlen   = 8'($urandom_range(0, 3));
      r.arsize  = 3'd2;
      r.arburst = 2'd1;
      if (lsu) lsu_m2s = r;
      else     ifu_m2s = r;
   endtask

   // Acts as master rready source and AXI slave until one burst completes; reports what it saw.
   task automatic serve(input int rv_pct, output bit who, output int bad, output bit tmo);
      bit in_data, done, hs, acc, rl, rr;
      int beat;
      logic [7:0] len;
      logic [31:0] dat;
      axi_r_s2m_t o, n;
      axi_r_m2s_t q;
      in_data = 0; done = 0; hs = 0; acc = 0; rl = 0; rr = 0;
      beat = 0; len = 0; dat = 0; who = 0; bad = 0;
      for (int c = 0; c < 400 && !done; c++) begin
         ifu_m2s.rready = 1'($urandom_range(0, 1));
         lsu_m2s.rready = 1'($urandom_range(0, 1));
         core_s2m = '0;
         if (!in_data) begin
            core_s2m.arready = 1'($urandom_range(0, 1));
         end else begin
            core_s2m.rvalid = ($urandom_range(0, 99) < rv_pct);
            dat = $urandom;
            core_s2m.rdata = dat;
            core_s2m.rlast = (beat == int'(len));
         end
         #1;
         hs = 0;
         acc = 0;
         if (!in_data) begin
            if (core_m2s.arvalid === 1'b1) begin
               who = owner_o;
               q = who ? lsu_m2s : ifu_m2s;
               o = who ? lsu_s2m : ifu_s2m;
               n = who ? ifu_s2m : lsu_s2m;
               if (q.arvalid !== 1'b1) bad++;
               if (core_m2s.araddr !== q.araddr || core_m2s.arlen !== q.arlen ||
                   core_m2s.arid !== q.arid || core_m2s.rready !== 1'b0) bad++;
               if (o.arready !== core_s2m.arready || n.arready !== 1'b0 || o.rvalid !== 1'b0) bad++;
               hs = core_s2m.arready;
               len = q.arlen;
            end else if (ifu_s2m.arready !== 1'b0 || lsu_s2m.arready !== 1'b0) begin
               bad++;
            end
         end else begin
            o = who ? lsu_s2m : ifu_s2m;
            n = who ? ifu_s2m : lsu_s2m;
            rr = who ? lsu_m2s.rready : ifu_m2s.rready;
            if (o.rvalid !== core_s2m.rvalid || o.arready !== 1'b0) bad++;
            if (core_s2m.rvalid && (o.rdata !== dat || o.rlast !== core_s2m.rlast)) bad++;
            if (n.rvalid !== 1'b0 || n.arready !== 1'b0) bad++;
            if (core_m2s.rready !== rr || core_m2s.arvalid !== 1'b0) bad++;
            acc = core_s2m.rvalid && rr;
            rl = core_s2m.rlast;
         end
         @(posedge clock);
         #1;
         if (hs) begin
            in_data = 1;
            if (who) lsu_m2s.arvalid = 1'b0;
            else     ifu_m2s.arvalid = 1'b0;
         end else if (acc) begin
            if (rl) done = 1;
            beat++;
         end
      end
      core_s2m = '0;
      tmo = !done;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      ifu_m2s = '0;
      lsu_m2s = '0;
      core_s2m = '0;
      core_s2m.arready = 1'b1;
      core_s2m.rvalid = 1'b1;
      core_s2m.rlast = 1'b1;
      repeat (2) @(posedge clock);
      #1;
      vectors++;
      if ({busy_o, owner_o, proto_err_o, core_m2s.arvalid, core_m2s.rready, ifu_s2m.arready,
           ifu_s2m.rvalid, lsu_s2m.arready, lsu_s2m.rvalid} !== 9'b0) begin
         miscompares++;
         $display("FAIL reset_state: got busy=%b owner=%b err=%b core_arv=%b core_rr=%b ifu_ar=%b ifu_rv=%b lsu_ar=%b lsu_rv=%b, need all 0",
                  busy_o, owner_o, proto_err_o, core_m2s.arvalid, core_m2s.rready, ifu_s2m.arready,
                  ifu_s2m.rvalid, lsu_s2m.arready, lsu_s2m.rvalid);
      end
      reset = 1'b0;
      @(posedge clock);
      #1;
      vectors++;
      if ({busy_o, ifu_s2m.arready, ifu_s2m.rvalid, lsu_s2m.arready, lsu_s2m.rvalid, core_m2s.arvalid} !== 6'b0) begin
         miscompares++;
         $display("FAIL idle_gating: got busy=%b ifu_ar=%b ifu_rv=%b lsu_ar=%b lsu_rv=%b core_arv=%b, need all 0",
                  busy_o, ifu_s2m.arready, ifu_s2m.rvalid, lsu_s2m.arready, lsu_s2m.rvalid, core_m2s.arvalid);
      end
      core_s2m = '0;
      m_last_lsu = 1'b1;
   endtask

   task automatic test_single_ifu();
      ifu_m2s = '0;
      ifu_m2s.arvalid = 1'b1;
      ifu_m2s.araddr = 32'h3000_0000;
      ifu_m2s.arlen = 8'd0;
      ifu_m2s.arid = 4'd3;
      ifu_m2s.arsize = 3'd2;
      ifu_m2s.arburst = 2'd1;
      #1;
      vectors++;
      if (core_m2s.arvalid !== 1'b0) begin
         miscompares++;
         $display("FAIL grant_bubble: core arvalid=%b in request cycle, need 0", core_m2s.arvalid);
      end
      @(posedge clock);
      #1;
      vectors++;
      if ({core_m2s.arvalid, core_m2s.araddr, core_m2s.arlen, busy_o, owner_o} !== {1'b1, 32'h3000_0000, 8'd0, 1'b1, 1'b0}) begin
         miscompares++;
         $display("FAIL ifu_ar: got arvalid=%b araddr=%h arlen=%0d busy=%b owner=%b, need 1 30000000 0 1 0",
                  core_m2s.arvalid, core_m2s.araddr, core_m2s.arlen, busy_o, owner_o);
      end
      core_s2m.arready = 1'b1;
      #1;
      vectors++;
      if ({ifu_s2m.arready, lsu_s2m.arready} !== 2'b10) begin
         miscompares++;
         $display("FAIL ifu_arready_route: got ifu=%b lsu=%b, need 1 0", ifu_s2m.arready, lsu_s2m.arready);
      end
      @(posedge clock);
      #1;
      ifu_m2s.arvalid = 1'b0;
      ifu_m2s.rready = 1'b1;
      core_s2m = '0;
      core_s2m.rvalid = 1'b1;
      core_s2m.rdata = 32'hDEAD_BEEF;
      core_s2m.rlast = 1'b1;
      #1;
      vectors++;
      if ({ifu_s2m.rvalid, ifu_s2m.rdata, lsu_s2m.rvalid, core_m2s.rready} !== {1'b1, 32'hDEAD_BEEF, 1'b0, 1'b1}) begin
         miscompares++;
         $display("FAIL ifu_rdata: got ifu_rv=%b rdata=%h lsu_rv=%b core_rr=%b, need 1 deadbeef 0 1",
                  ifu_s2m.rvalid, ifu_s2m.rdata, lsu_s2m.rvalid, core_m2s.rready);
      end
      @(posedge clock);
      #1;
      core_s2m = '0;
      ifu_m2s.rready = 1'b0;
      vectors++;
      if ({busy_o, proto_err_o} !== 2'b00) begin
         miscompares++;
         $display("FAIL single_done: got busy=%b err=%b, need 0 0", busy_o, proto_err_o);
      end
      m_last_lsu = 1'b0;
   endtask

   task automatic test_simultaneous();
      bit who, tmo, exp;
      int bad;
      do_reset();
      arm(1'b0);
      arm(1'b1);
      for (int k = 0; k < 6; k++) begin
         exp = exp_winner(1'b1, 1'b1);
         serve(70, who, bad, tmo);
         vectors++;
         if (who !== exp || bad != 0 || tmo) begin
            miscompares++;
            $display("FAIL tie_grant[%0d]: got owner=%b bad=%0d timeout=%b, need owner=%b bad=0 timeout=0",
                     k, who, bad, tmo, exp);
         end
         m_last_lsu = exp;
         if (!ifu_m2s.arvalid) arm(1'b0);
         if (!lsu_m2s.arvalid) arm(1'b1);
      end
      do_reset();
   endtask

   task automatic test_burst_ownership();
      int leak, bad;
      bit who, tmo;
      ifu_m2s = '0;
      ifu_m2s.arvalid = 1'b1;
      ifu_m2s.araddr = 32'h1234_5670;
      ifu_m2s.arlen = 8'd3;
      lsu_m2s = '0;
      @(posedge clock);
      #1;
      core_s2m.arready = 1'b1;
      @(posedge clock);
      #1;
      ifu_m2s.arvalid = 1'b0;
      ifu_m2s.rready = 1'b1;
      lsu_m2s.arvalid = 1'b1;
      lsu_m2s.araddr = 32'h8000_1000;
      lsu_m2s.arlen = 8'd0;
      lsu_m2s.rready = 1'b1;
      leak = 0;
      for (int b = 0; b < 4; b++) begin
         core_s2m.arready = 1'b1;
         core_s2m.rvalid = 1'b1;
         core_s2m.rdata = $urandom;
         core_s2m.rlast = (b == 3);
         #1;
         if (lsu_s2m.arready !== 1'b0 || lsu_s2m.rvalid !== 1'b0) leak++;
         if (ifu_s2m.rvalid !== 1'b1 || ifu_s2m.rdata !== core_s2m.rdata) leak++;
         @(posedge clock);
         #1;
      end
      core_s2m = '0;
      vectors++;
      if (leak != 0) begin
         miscompares++;
         $display("FAIL burst_ownership: %0d beats leaked to LSU or misrouted, need 0", leak);
      end
      #1;
      vectors++;
      if ({core_m2s.arvalid, busy_o} !== 2'b00) begin
         miscompares++;
         $display("FAIL burst_bubble: got arvalid=%b busy=%b one cycle after rlast, need 0 0", core_m2s.arvalid, busy_o);
      end
      @(posedge clock);
      #1;
      vectors++;
      if ({core_m2s.arvalid, owner_o, core_m2s.araddr} !== {1'b1, 1'b1, 32'h8000_1000}) begin
         miscompares++;
         $display("FAIL lsu_after_burst: got arvalid=%b owner=%b araddr=%h, need 1 1 80001000",
                  core_m2s.arvalid, owner_o, core_m2s.araddr);
      end
      serve(80, who, bad, tmo);
      vectors++;
      if (who !== 1'b1 || bad != 0 || tmo) begin
         miscompares++;
         $display("FAIL lsu_drain: got owner=%b bad=%0d timeout=%b, need 1 0 0", who, bad, tmo);
      end
      m_last_lsu = 1'b1;
   endtask

   task automatic test_proto_err();
      bit who, tmo;
      int bad;
      ifu_m2s = '0;
      lsu_m2s = '0;
      ifu_m2s.arvalid = 1'b1;
      ifu_m2s.araddr = 32'h0000_4000;
      ifu_m2s.arlen = 8'd1;
      @(posedge clock);
      #1;
      core_s2m.arready = 1'b1;
      @(posedge clock);
      #1;
      ifu_m2s.arvalid = 1'b0;
      ifu_m2s.rready = 1'b1;
      core_s2m = '0;
      core_s2m.rvalid = 1'b1;
      core_s2m.rlast = 1'b1;
      core_s2m.rdata = 32'h0BAD_0BAD;
      #1;
      vectors++;
      if (proto_err_o !== 1'b0) begin
         miscompares++;
         $display("FAIL err_not_early: got %b during beat, need 0", proto_err_o);
      end
      @(posedge clock);
      #1;
      core_s2m = '0;
      vectors++;
      if ({proto_err_o, busy_o} !== 2'b10) begin
         miscompares++;
         $display("FAIL err_early_rlast: got err=%b busy=%b, need 1 0", proto_err_o, busy_o);
      end
      m_last_lsu = 1'b0;
      arm(1'b1);
      serve(70, who, bad, tmo);
      vectors++;
      if (proto_err_o !== 1'b1 || who !== 1'b1 || tmo) begin
         miscompares++;
         $display("FAIL err_sticky: got err=%b owner=%b timeout=%b, need 1 1 0", proto_err_o, who, tmo);
      end
      do_reset();
      vectors++;
      if (proto_err_o !== 1'b0) begin
         miscompares++;
         $display("FAIL err_cleared: got %b after reset, need 0", proto_err_o);
      end
   endtask

   task automatic test_missing_rlast();
      ifu_m2s = '0;
      ifu_m2s.arvalid = 1'b1;
      ifu_m2s.arlen = 8'd0;
      @(posedge clock);
      #1;
      core_s2m.arready = 1'b1;
      @(posedge clock);
      #1;
      ifu_m2s.arvalid = 1'b0;
      ifu_m2s.rready = 1'b1;
      core_s2m = '0;
      core_s2m.rvalid = 1'b1;
      core_s2m.rlast = 1'b0;
      @(posedge clock);
      #1;
      vectors++;
      if ({proto_err_o, busy_o} !== 2'b11) begin
         miscompares++;
         $display("FAIL err_missing_rlast: got err=%b busy=%b, need 1 1", proto_err_o, busy_o);
      end
      core_s2m.rlast = 1'b1;
      @(posedge clock);
      #1;
      core_s2m = '0;
      vectors++;
      if (busy_o !== 1'b0) begin
         miscompares++;
         $display("FAIL late_rlast_exit: got busy=%b, need 0", busy_o);
      end
      do_reset();
   endtask

   task automatic test_reset_mid_data();
      bit who, tmo;
      int bad;
      ifu_m2s = '0;
      ifu_m2s.arvalid = 1'b1;
      ifu_m2s.arlen = 8'd3;
      @(posedge clock);
      #1;
      core_s2m.arready = 1'b1;
      @(posedge clock);
      #1;
      ifu_m2s.arvalid = 1'b0;
      ifu_m2s.rready = 1'b1;
      core_s2m = '0;
      core_s2m.rvalid = 1'b1;
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b1;
      @(posedge clock);
      #1;
      vectors++;
      if ({busy_o, core_m2s.arvalid, core_m2s.rready, ifu_s2m.rvalid, lsu_s2m.rvalid} !== 5'b0) begin
         miscompares++;
         $display("FAIL reset_mid_data: got busy=%b arv=%b rr=%b ifu_rv=%b lsu_rv=%b, need all 0",
                  busy_o, core_m2s.arvalid, core_m2s.rready, ifu_s2m.rvalid, lsu_s2m.rvalid);
      end
      reset = 1'b0;
      core_s2m = '0;
      ifu_m2s = '0;
      m_last_lsu = 1'b1;
      arm(1'b1);
      serve(70, who, bad, tmo);
      vectors++;
      if (who !== 1'b1 || bad != 0 || tmo || proto_err_o !== 1'b0) begin
         miscompares++;
         $display("FAIL post_reset_grant: got owner=%b bad=%0d timeout=%b err=%b, need 1 0 0 0",
                  who, bad, tmo, proto_err_o);
      end
      m_last_lsu = 1'b1;
   endtask

   task automatic test_random();
      bit who, tmo, exp;
      int bad;
      do_reset();
      for (int k = 0; k < 24; k++) begin
         if (!ifu_m2s.arvalid && $urandom_range(0, 1) == 1) arm(1'b0);
         if (!lsu_m2s.arvalid && $urandom_range(0, 1) == 1) arm(1'b1);
         if (!ifu_m2s.arvalid && !lsu_m2s.arvalid) arm(1'($urandom_range(0, 1)));
         exp = exp_winner(ifu_m2s.arvalid, lsu_m2s.arvalid);
         serve(60, who, bad, tmo);
         vectors++;
         if (who !== exp || bad != 0 || tmo || proto_err_o !== 1'b0) begin
            miscompares++;
            $display("FAIL random[%0d]: got owner=%b bad=%0d timeout=%b err=%b, need owner=%b 0 0 0",
                     k, who, bad, tmo, proto_err_o, exp);
         end
         m_last_lsu = exp;
      end
   endtask

   initial begin
      vectors = 0;
      miscompares = 0;
      m_last_lsu = 1'b1;
      test_reset();
      test_single_ifu();
      test_simultaneous();
      test_burst_ownership();
      test_proto_err();
      test_missing_rlast();
      test_reset_mid_data();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
